rom_arbiter: RTL and testbench

- Shares the single-port synchronous 8192x24 program ROM between two requesters.
  - Port A: instruction fetch.
  - Port B: data/constant read.
- Grants at most one read per cycle and drives the ROM address and active-low chip-select.
- Routes the one-cycle-later ROM data back to the winning port with a response strobe, and holds each port's last read word stable.
- Sits between the CPU front end / load unit and the ROM macro.

---
 rtl/rom_arbiter.sv | 93 +++++++++
 tb/tb_rom_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a single-port synchronous ROM: grants one read per
// cycle, drives the ROM, and returns the next-cycle data to the winning port.
module rom_arbiter #(
  parameter int ADDR_W        = 13,
  parameter int DATA_W        = 24,
  parameter int PRIORITY_MODE = 0,
  parameter int STARVE_MAX    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_cs_b,
  input  logic [DATA_W-1:0] rom_dout
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic              w_b_wins;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              r_prio_b;
  logic [3:0]        r_starve;
  logic              r_vld_a_p1;
  logic              r_vld_b_p1;
  logic [DATA_W-1:0] r_hold_a_p1;
  logic [DATA_W-1:0] r_hold_b_p1;

  // Stage p0: grant decision and ROM drive, all combinational.
  // r_prio_b is set when A won last, so B takes the next contention in round-robin.
  assign w_b_wins = (PRIORITY_MODE == 0) ? r_prio_b : (r_starve == STARVE_LIM);
  assign w_gnt_b  = req_b & (~req_a | w_b_wins);
  assign w_gnt_a  = req_a & ~w_gnt_b;

  assign gnt_a       = w_gnt_a;
  assign gnt_b       = w_gnt_b;
  assign rom_cs_b    = ~(w_gnt_a | w_gnt_b);
  assign rom_address = w_gnt_b ? addr_b : addr_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio_b <= 1'b0;
    end else if (w_gnt_a) begin
      r_prio_b <= 1'b1;
    end else if (w_gnt_b) begin
      r_prio_b <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (PRIORITY_MODE == 0) || w_gnt_b || !req_b) begin
      r_starve <= 4'd0;
    end else if (r_starve != STARVE_LIM) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // Stage p1: ROM data arrives; grants issued during reset are squashed here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_a_p1 <= 1'b0;
      r_vld_b_p1 <= 1'b0;
    end else begin
      r_vld_a_p1 <= w_gnt_a;
      r_vld_b_p1 <= w_gnt_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_a_p1 <= '0;
      r_hold_b_p1 <= '0;
    end else begin
      if (r_vld_a_p1) r_hold_a_p1 <= rom_dout;
      if (r_vld_b_p1) r_hold_b_p1 <= rom_dout;
    end
  end

  assign rvalid_a = r_vld_a_p1;
  assign rvalid_b = r_vld_b_p1;
  assign rdata_a  = r_vld_a_p1 ? rom_dout : r_hold_a_p1;
  assign rdata_b  = r_vld_b_p1 ? rom_dout : r_hold_b_p1;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench: a round-robin instance and a fixed-priority instance share
// one stimulus stream; a monitor pops expected responses as rvalid appears.
module tb_rom_arbiter;

  typedef struct {
    int          cyc;
    bit          port;   // 0 = A, 1 = B
    logic [23:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [12:0] addr_a = '0;
  logic [12:0] addr_b = '0;

  logic [1:0]  gnt_a, gnt_b, rvalid_a, rvalid_b, cs_b;
  logic [12:0] rom_addr [2];
  logic [23:0] rdata_a [2];
  logic [23:0] rdata_b [2];
  logic [23:0] rom_dout [2];

  logic [23:0] mem [8192];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   started = 0;
  int   m_last_b [2];
  int   m_denied [2];
  logic [23:0] h_a [2];
  logic [23:0] h_b [2];
  rsp_t q0[$];
  rsp_t q1[$];

  rom_arbiter #(.ADDR_W(13), .DATA_W(24), .PRIORITY_MODE(0), .STARVE_MAX(4)) u0 (
    .clk(clk), .reset(reset),
    .req_a(req_a), .addr_a(addr_a), .gnt_a(gnt_a[0]), .rvalid_a(rvalid_a[0]), .rdata_a(rdata_a[0]),
    .req_b(req_b), .addr_b(addr_b), .gnt_b(gnt_b[0]), .rvalid_b(rvalid_b[0]), .rdata_b(rdata_b[0]),
    .rom_address(rom_addr[0]), .rom_cs_b(cs_b[0]), .rom_dout(rom_dout[0])
  );

  rom_arbiter #(.ADDR_W(13), .DATA_W(24), .PRIORITY_MODE(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .reset(reset),
    .req_a(req_a), .addr_a(addr_a), .gnt_a(gnt_a[1]), .rvalid_a(rvalid_a[1]), .rdata_a(rdata_a[1]),
    .req_b(req_b), .addr_b(addr_b), .gnt_b(gnt_b[1]), .rvalid_b(rvalid_b[1]), .rdata_b(rdata_b[1]),
    .rom_address(rom_addr[1]), .rom_cs_b(cs_b[1]), .rom_dout(rom_dout[1])
  );

  always #5 clk = ~clk;

  // Synchronous ROM models, one per instance.
  always @(posedge clk) begin
    if (!cs_b[0]) rom_dout[0] <= mem[rom_addr[0]];
    if (!cs_b[1]) rom_dout[1] <= mem[rom_addr[1]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle of stimulus; called at a falling edge.
  task automatic step(input bit rst, input bit ra, input logic [12:0] aa,
                      input bit rb, input logic [12:0] ab);
    reset  = rst;
    req_a  = ra;
    addr_a = aa;
    req_b  = rb;
    addr_b = ab;
    #1;
    for (int k = 0; k < 2; k++) begin
      bit   b_pri;
      bit   eb;
      bit   ea;
      rsp_t e;
      b_pri = (k == 0) ? (m_last_b[k] == 0) : (m_denied[k] == 4);
      eb = rb && (!ra || b_pri);
      ea = ra && !eb;
      chk($sformatf("u%0d gnt_a", k), 32'(gnt_a[k]), 32'(ea));
      chk($sformatf("u%0d gnt_b", k), 32'(gnt_b[k]), 32'(eb));
      chk($sformatf("u%0d rom_cs_b", k), 32'(cs_b[k]), 32'(!(ea || eb)));
      chk($sformatf("u%0d rom_address", k), 32'(rom_addr[k]), 32'(eb ? ab : aa));
      if (!rst && (ea || eb)) begin
        e.cyc  = cyc + 1;
        e.port = eb;
        e.data = mem[eb ? ab : aa];
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (rst) begin
        m_last_b[k] = 1;
        m_denied[k] = 0;
      end else begin
        if (ea) m_last_b[k] = 0;
        if (eb) m_last_b[k] = 1;
        if (k == 1 && rb && !eb) m_denied[k] = (m_denied[k] < 4) ? m_denied[k] + 1 : 4;
        else m_denied[k] = 0;
      end
    end
    @(negedge clk);
  endtask

  // Monitor: samples 1 time unit after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < 2; k++) begin
        logic va, vb;
        logic [23:0] da, db;
        int   qs;
        rsp_t e;
        va = rvalid_a[k];
        vb = rvalid_b[k];
        da = rdata_a[k];
        db = rdata_b[k];
        qs = (k == 0) ? q0.size() : q1.size();
        if (reset) begin
          chk($sformatf("u%0d rvalid after reset", k), {30'd0, va, vb}, 32'd0);
          chk($sformatf("u%0d rdata_a after reset", k), 32'(da), 32'd0);
          chk($sformatf("u%0d rdata_b after reset", k), 32'(db), 32'd0);
          h_a[k] = '0;
          h_b[k] = '0;
          if (k == 0) q0.delete(); else q1.delete();
        end else if (started) begin
          if (va || vb) begin
            if (qs == 0) begin
              chk($sformatf("u%0d unexpected rvalid", k), {30'd0, va, vb}, 32'd0);
            end else begin
              if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
              chk($sformatf("u%0d rvalid cycle", k), 32'(cyc), 32'(e.cyc));
              chk($sformatf("u%0d rvalid port", k), {30'd0, va, vb},
                  e.port ? 32'd1 : 32'd2);
              if (e.port) begin
                chk($sformatf("u%0d rdata_b", k), 32'(db), 32'(e.data));
                h_b[k] = e.data;
              end else begin
                chk($sformatf("u%0d rdata_a", k), 32'(da), 32'(e.data));
                h_a[k] = e.data;
              end
            end
          end else if (qs != 0) begin
            e = (k == 0) ? q0[0] : q1[0];
            if (e.cyc <= cyc) begin
              chk($sformatf("u%0d missing rvalid", k), 32'd0, 32'd1);
              if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
          end
          if (!va) chk($sformatf("u%0d rdata_a hold", k), 32'(da), 32'(h_a[k]));
          if (!vb) chk($sformatf("u%0d rdata_b hold", k), 32'(db), 32'(h_b[k]));
        end
      end
      if (reset) started = 1;
    end
  end

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 24'((32'(i) * 32'h9E3779B1) >> 5);
    mem[13'h0005] = 24'hA5A5A5;
    mem[13'h0001] = 24'h111111;
    mem[13'h0002] = 24'h222222;
    mem[13'h0010] = 24'h0F0F0F;
    mem[13'h1FFF] = 24'hFEDCBA;
    for (int k = 0; k < 2; k++) begin
      m_last_b[k] = 1;
      m_denied[k] = 0;
      h_a[k] = '0;
      h_b[k] = '0;
    end

    step(1, 0, 13'h0, 0, 13'h0);
    step(1, 0, 13'h0, 0, 13'h0);

    // Single port A read, then hold for several idle cycles.
    step(0, 1, 13'h0005, 0, 13'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 13'h0, 0, 13'h0);

    // Both requesting continuously from a fresh reset.
    step(1, 0, 13'h0, 0, 13'h0);
    for (int i = 0; i < 15; i++) step(0, 1, 13'h0010, 1, 13'h1FFF);

    // Consecutive A then B reads: no cross-port corruption.
    step(0, 0, 13'h0, 0, 13'h0);
    step(0, 1, 13'h0001, 0, 13'h0);
    step(0, 0, 13'h0, 1, 13'h0002);
    step(0, 0, 13'h0, 0, 13'h0);

    // Reset asserted during a B grant, then contention.
    step(1, 0, 13'h0, 1, 13'h0444);
    step(0, 1, 13'h0020, 1, 13'h0021);
    step(0, 1, 13'h0020, 1, 13'h0021);

    // Ten idle cycles.
    for (int i = 0; i < 10; i++) step(0, 0, 13'h0, 0, 13'h0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 60) == 0,
           $urandom_range(0, 3) != 0, 13'($urandom),
           $urandom_range(0, 3) != 0, 13'($urandom));
    end

    step(0, 0, 13'h0, 0, 13'h0);
    step(0, 0, 13'h0, 0, 13'h0);
    chk("u0 responses drained", 32'(q0.size()), 32'd0);
    chk("u1 responses drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
